// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM encoding, the NOP
// used by the pipeline-register flush logic, and the load-use match function.
package hazard_pkg;

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] ST_LU_STALL = 2'd2;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;  // addi x0, x0, 0

   // x0 is never a real producer, so a load targeting it cannot create a hazard.
   function automatic logic load_use_hit(
      input logic       mem_read,
      input logic [4:0] rd,
      input logic [4:0] rs1,
      input logic [4:0] rs2,
      input logic       uses_rs1,
      input logic       uses_rs2
   );
      return mem_read && (rd != 5'd0) &&
             ((uses_rs1 && (rd == rs1)) || (uses_rs2 && (rd == rs2)));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (inc && (count_reg != {W{1'b1}})) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer for the 5-stage RV32I core: freezes, bubbles or flushes
// the pipeline for memory waits, EX redirects and load-use hazards.
module hazard_control_unit
   import hazard_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ID_EX_MemRead,
   input  logic [4:0]       ID_EX_RDes,
   input  logic [4:0]       IF_ID_RS1,
   input  logic [4:0]       IF_ID_RS2,
   input  logic             IF_ID_UsesRS1,
   input  logic             IF_ID_UsesRS2,
   input  logic             EX_Redirect,
   input  logic             EX_MEM_MemReq,
   input  logic             dmem_ready,
   output logic             PC_Write,
   output logic             IF_ID_Write,
   output logic             ID_EX_Write,
   output logic             EX_MEM_Write,
   output logic             MEM_WB_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Flush,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count,
   output logic             err_timeout
);

   localparam int              WAIT_W     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

   logic [1:0]        state_reg, state_next;
   logic [WAIT_W-1:0] wait_cnt_reg;
   logic              err_timeout_reg;
   logic              mem_wait, load_use;
   logic              mem_stall, stall_inc, flush_inc;

   assign mem_wait = EX_MEM_MemReq && !dmem_ready;
   assign load_use = load_use_hit(ID_EX_MemRead, ID_EX_RDes, IF_ID_RS1, IF_ID_RS2,
                                  IF_ID_UsesRS1, IF_ID_UsesRS2);

   always_comb begin
      PC_Write     = 1'b1;
      IF_ID_Write  = 1'b1;
      ID_EX_Write  = 1'b1;
      EX_MEM_Write = 1'b1;
      MEM_WB_Write = 1'b1;
      IF_ID_Flush  = 1'b0;
      ID_EX_Flush  = 1'b0;
      state_next   = state_reg;
      mem_stall    = 1'b0;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;

      case (state_reg)
         ST_MEM_WAIT: begin
            // Redirects and load-use are held off; the frozen pipeline keeps
            // presenting them, so they are picked up once the wait ends.
            if (mem_wait) begin
               PC_Write     = 1'b0;
               IF_ID_Write  = 1'b0;
               ID_EX_Write  = 1'b0;
               EX_MEM_Write = 1'b0;
               MEM_WB_Write = 1'b0;
               mem_stall    = 1'b1;
               stall_inc    = 1'b1;
            end else begin
               state_next = ST_RUN;
            end
         end
         default: begin
            // RUN and LU_STALL share rules; any illegal code also recovers here.
            state_next = ST_RUN;
            if (mem_wait) begin
               PC_Write     = 1'b0;
               IF_ID_Write  = 1'b0;
               ID_EX_Write  = 1'b0;
               EX_MEM_Write = 1'b0;
               MEM_WB_Write = 1'b0;
               mem_stall    = 1'b1;
               stall_inc    = 1'b1;
               state_next   = ST_MEM_WAIT;
            end else if (EX_Redirect) begin
               IF_ID_Flush = 1'b1;
               ID_EX_Flush = 1'b1;
               flush_inc   = 1'b1;
            end else if (load_use) begin
               PC_Write    = 1'b0;
               IF_ID_Write = 1'b0;
               ID_EX_Flush = 1'b1;
               stall_inc   = 1'b1;
               state_next  = ST_LU_STALL;
            end
         end
      endcase

      // While reset is held the pipeline sees plain RUN behaviour.
      if (rst) begin
         PC_Write     = 1'b1;
         IF_ID_Write  = 1'b1;
         ID_EX_Write  = 1'b1;
         EX_MEM_Write = 1'b1;
         MEM_WB_Write = 1'b1;
         IF_ID_Flush  = 1'b0;
         ID_EX_Flush  = 1'b0;
         mem_stall    = 1'b0;
         stall_inc    = 1'b0;
         flush_inc    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_RUN;
      end else begin
         state_reg <= state_next;
      end
   end

   // Wait counter spans every frozen memory cycle, including the entry cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt_reg    <= '0;
         err_timeout_reg <= 1'b0;
      end else begin
         if (!mem_stall) begin
            wait_cnt_reg <= '0;
         end else if (wait_cnt_reg != {WAIT_W{1'b1}}) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
            if ((MEM_TIMEOUT != 0) && ((wait_cnt_reg + 1'b1) == WAIT_LIMIT)) begin
               err_timeout_reg <= 1'b1;
            end
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_inc),
      .count (flush_count)
   );

   assign state_o     = state_reg;
   assign err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: expected cycle outputs are queued as
// stimulus is applied and compared on the falling edge of the same cycle.
module tb_hazard_control_unit;

   localparam int CNT_W       = 4;
   localparam int MEM_TIMEOUT = 4;

   logic             clk, rst;
   logic             ID_EX_MemRead;
   logic [4:0]       ID_EX_RDes, IF_ID_RS1, IF_ID_RS2;
   logic             IF_ID_UsesRS1, IF_ID_UsesRS2;
   logic             EX_Redirect, EX_MEM_MemReq, dmem_ready;
   logic             PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write;
   logic             IF_ID_Flush, ID_EX_Flush;
   logic [1:0]       state_o;
   logic [CNT_W-1:0] stall_cycles, flush_count;
   logic             err_timeout;

   hazard_control_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk           (clk),
      .rst           (rst),
      .ID_EX_MemRead (ID_EX_MemRead),
      .ID_EX_RDes    (ID_EX_RDes),
      .IF_ID_RS1     (IF_ID_RS1),
      .IF_ID_RS2     (IF_ID_RS2),
      .IF_ID_UsesRS1 (IF_ID_UsesRS1),
      .IF_ID_UsesRS2 (IF_ID_UsesRS2),
      .EX_Redirect   (EX_Redirect),
      .EX_MEM_MemReq (EX_MEM_MemReq),
      .dmem_ready    (dmem_ready),
      .PC_Write      (PC_Write),
      .IF_ID_Write   (IF_ID_Write),
      .ID_EX_Write   (ID_EX_Write),
      .EX_MEM_Write  (EX_MEM_Write),
      .MEM_WB_Write  (MEM_WB_Write),
      .IF_ID_Flush   (IF_ID_Flush),
      .ID_EX_Flush   (ID_EX_Flush),
      .state_o       (state_o),
      .stall_cycles  (stall_cycles),
      .flush_count   (flush_count),
      .err_timeout   (err_timeout)
   );

   typedef struct packed {
      logic       memread;
      logic [4:0] rdes;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic       redir;
      logic       memreq;
      logic       ready;
   } in_t;

   typedef struct packed {
      logic [4:0]       en;   // {PC, IF_ID, ID_EX, EX_MEM, MEM_WB} write enables
      logic [1:0]       fl;   // {IF_ID_Flush, ID_EX_Flush}
      logic [1:0]       st;
      logic [CNT_W-1:0] stall;
      logic [CNT_W-1:0] flush;
      logic             err;
   } exp_t;

   localparam logic [4:0] EN_ALL  = 5'b11111;
   localparam logic [4:0] EN_NONE = 5'b00000;
   localparam logic [4:0] EN_LU   = 5'b00111;
   localparam logic [1:0] FL_NONE = 2'b00;
   localparam logic [1:0] FL_BUB  = 2'b01;
   localparam logic [1:0] FL_ALL  = 2'b11;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   txn    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic in_t mkin(input logic memread, input int rdes, input int rs1, input int rs2,
                                input logic u1, input logic u2, input logic redir,
                                input logic memreq, input logic ready);
      in_t r;
      r.memread = memread;
      r.rdes    = 5'(rdes);
      r.rs1     = 5'(rs1);
      r.rs2     = 5'(rs2);
      r.u1      = u1;
      r.u2      = u2;
      r.redir   = redir;
      r.memreq  = memreq;
      r.ready   = ready;
      return r;
   endfunction

   function automatic exp_t mk(input logic [4:0] en, input logic [1:0] fl, input int st,
                               input int stall, input int flush, input logic err);
      exp_t r;
      r.en    = en;
      r.fl    = fl;
      r.st    = 2'(st);
      r.stall = CNT_W'(stall);
      r.flush = CNT_W'(flush);
      r.err   = err;
      return r;
   endfunction

   task automatic drive(input in_t i);
      ID_EX_MemRead = i.memread;
      ID_EX_RDes    = i.rdes;
      IF_ID_RS1     = i.rs1;
      IF_ID_RS2     = i.rs2;
      IF_ID_UsesRS1 = i.u1;
      IF_ID_UsesRS2 = i.u2;
      EX_Redirect   = i.redir;
      EX_MEM_MemReq = i.memreq;
      dmem_ready    = i.ready;
   endtask

   task automatic check_one(input string tag);
      exp_t       e;
      logic [4:0] en_obs;
      logic [1:0] fl_obs;
      e      = exp_q.pop_front();
      en_obs = {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write};
      fl_obs = {IF_ID_Flush, ID_EX_Flush};
      checks++;
      assert (en_obs === e.en) else begin
         errors++;
         $error("FAIL %s enables: observed %b expected %b", tag, en_obs, e.en);
      end
      checks++;
      assert (fl_obs === e.fl) else begin
         errors++;
         $error("FAIL %s flushes: observed %b expected %b", tag, fl_obs, e.fl);
      end
      checks++;
      assert (state_o === e.st) else begin
         errors++;
         $error("FAIL %s state: observed %0d expected %0d", tag, state_o, e.st);
      end
      checks++;
      assert (stall_cycles === e.stall) else begin
         errors++;
         $error("FAIL %s stall_cycles: observed %0d expected %0d", tag, stall_cycles, e.stall);
      end
      checks++;
      assert (flush_count === e.flush) else begin
         errors++;
         $error("FAIL %s flush_count: observed %0d expected %0d", tag, flush_count, e.flush);
      end
      checks++;
      assert (err_timeout === e.err) else begin
         errors++;
         $error("FAIL %s err_timeout: observed %b expected %b", tag, err_timeout, e.err);
      end
      $display("txn %0d %s: en=%b fl=%b st=%0d stall=%0d flush=%0d err=%b",
               txn, tag, en_obs, fl_obs, state_o, stall_cycles, flush_count, err_timeout);
      txn++;
   endtask

   task automatic step(input in_t i, input exp_t e, input string tag);
      drive(i);
      exp_q.push_back(e);
      @(negedge clk);
      check_one(tag);
      @(posedge clk);
      #1;
   endtask

   in_t idle, nl_rd0, nl_lui, nl_itype, lu_rs1, lu_rs2, redir_lu;
   in_t mw_redir, md_redir, redir, memwait;

   initial begin
      idle     = mkin(0, 0, 0, 0, 0, 0, 0, 0, 1);
      nl_rd0   = mkin(1, 0, 0, 7, 1, 1, 0, 0, 1);
      nl_lui   = mkin(1, 5, 5, 5, 0, 0, 0, 0, 1);
      nl_itype = mkin(1, 5, 9, 5, 1, 0, 0, 0, 1);
      lu_rs1   = mkin(1, 5, 5, 7, 1, 1, 0, 0, 1);
      lu_rs2   = mkin(1, 5, 9, 5, 1, 1, 0, 0, 1);
      redir_lu = mkin(1, 5, 5, 7, 1, 1, 1, 0, 1);
      mw_redir = mkin(0, 0, 0, 0, 0, 0, 1, 1, 0);
      md_redir = mkin(0, 0, 0, 0, 0, 0, 1, 1, 1);
      redir    = mkin(0, 0, 0, 0, 0, 0, 1, 0, 1);
      memwait  = mkin(0, 0, 0, 0, 0, 0, 0, 1, 0);

      rst = 1'b1;
      drive(idle);
      exp_q.push_back(mk(EN_ALL, FL_NONE, 0, 0, 0, 1'b0));
      @(negedge clk);
      check_one("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      step(idle,     mk(EN_ALL, FL_NONE, 0, 0, 0, 1'b0), "idle");
      step(nl_rd0,   mk(EN_ALL, FL_NONE, 0, 0, 0, 1'b0), "load_rd_x0");
      step(nl_lui,   mk(EN_ALL, FL_NONE, 0, 0, 0, 1'b0), "lui_no_src");
      step(nl_itype, mk(EN_ALL, FL_NONE, 0, 0, 0, 1'b0), "rs2_unused");
      step(lu_rs1,   mk(EN_LU,  FL_BUB,  0, 0, 0, 1'b0), "load_use_rs1");
      step(idle,     mk(EN_ALL, FL_NONE, 2, 1, 0, 1'b0), "lu_stall_rs1");
      step(lu_rs2,   mk(EN_LU,  FL_BUB,  0, 1, 0, 1'b0), "load_use_rs2");
      step(idle,     mk(EN_ALL, FL_NONE, 2, 2, 0, 1'b0), "lu_stall_rs2");
      step(redir_lu, mk(EN_ALL, FL_ALL,  0, 2, 0, 1'b0), "redirect_over_lu");
      step(idle,     mk(EN_ALL, FL_NONE, 0, 2, 1, 1'b0), "after_redirect");

      // Memory wait with a redirect pending: redirect is only taken after exit.
      step(mw_redir, mk(EN_NONE, FL_NONE, 0, 2, 1, 1'b0), "mem_wait_1");
      step(mw_redir, mk(EN_NONE, FL_NONE, 1, 3, 1, 1'b0), "mem_wait_2");
      step(mw_redir, mk(EN_NONE, FL_NONE, 1, 4, 1, 1'b0), "mem_wait_3");
      step(md_redir, mk(EN_ALL,  FL_NONE, 1, 5, 1, 1'b0), "mem_ready");
      step(redir,    mk(EN_ALL,  FL_ALL,  0, 5, 1, 1'b0), "held_redirect");
      step(idle,     mk(EN_ALL,  FL_NONE, 0, 5, 2, 1'b0), "after_wait");

      // Timeout: err_timeout appears after the 4th frozen cycle.
      step(memwait, mk(EN_NONE, FL_NONE, 0, 5,  2, 1'b0), "tmo_1");
      step(memwait, mk(EN_NONE, FL_NONE, 1, 6,  2, 1'b0), "tmo_2");
      step(memwait, mk(EN_NONE, FL_NONE, 1, 7,  2, 1'b0), "tmo_3");
      step(memwait, mk(EN_NONE, FL_NONE, 1, 8,  2, 1'b0), "tmo_4");
      step(memwait, mk(EN_NONE, FL_NONE, 1, 9,  2, 1'b1), "tmo_5");
      step(memwait, mk(EN_NONE, FL_NONE, 1, 10, 2, 1'b1), "tmo_6");

      // Asynchronous reset mid-wait, inputs still requesting a wait.
      rst = 1'b1;
      #1;
      exp_q.push_back(mk(EN_ALL, FL_NONE, 0, 0, 0, 1'b0));
      check_one("async_rst");
      drive(idle);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Saturation of the 4-bit stall counter over 20 load-use events.
      for (int i = 0; i < 20; i++) begin
         step(lu_rs1, mk(EN_LU,  FL_BUB,  0, (i < 15) ? i : 15, 0, 1'b0), "sat_lu");
         step(idle,   mk(EN_ALL, FL_NONE, 2, (i + 1 < 15) ? i + 1 : 15, 0, 1'b0), "sat_bubble");
      end
      step(idle, mk(EN_ALL, FL_NONE, 0, 15, 0, 1'b0), "sat_hold");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
